// File: rtl/dump_pkg.sv
// dump_pkg
// Shared definitions for register_dump_unit and its word serializer:
// FSM state encoding, default word geometry, the header byte and a
// counter-width helper.
package dump_pkg;

  localparam int NB_DATA_DEF    = 32;
  localparam int NB_BYTE_DEF    = 8;
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_HDR_WAIT = 3'd2,
    ST_READ     = 3'd3,
    ST_LATCH    = 3'd4,
    ST_SEND     = 3'd5,
    ST_WAIT_TX  = 3'd6,
    ST_DONE     = 3'd7
  } dump_state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// word_serializer
// Holds one captured register word and hands it out one byte at a time,
// least significant byte first.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_clear          : zero the byte counter (start of a dump)
//   i_load           : capture i_word, byte counter back to 0
//   i_shift          : advance to the next byte
//   i_word           : word to capture
//   o_byte           : byte currently at the bottom of the shift register
//   o_last_byte      : current byte is the last one of the word
module word_serializer
  import dump_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last_byte
);

  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int CNT_W = cnt_width(BPW);

  logic [NB_DATA-1:0] shift_d, shift_q;
  logic [CNT_W-1:0]   byte_cnt_d, byte_cnt_q;

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (i_load) begin
      shift_d    = i_word;
      byte_cnt_d = '0;
    end else if (i_shift) begin
      shift_d    = shift_q >> NB_BYTE;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end else if (i_clear) begin
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign o_byte      = shift_q[NB_BYTE-1:0];
  assign o_last_byte = (byte_cnt_q == CNT_W'(BPW - 1));

endmodule

// File: rtl/register_dump_unit.sv
// register_dump_unit
// Walks every register of the decode-stage bank through its registered
// debug read port and streams each word, LSB byte first, into the UART
// transmitter's start/done handshake.
// Optional feature: define DUMP_HEADER_EN to prefix the stream with one
// header byte (0xA5).
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_start          : dump request, honoured only while idle
//   o_addr_r         : read address to the bank
//   i_data_r         : bank read data, valid one cycle after o_addr_r
//   o_tx_data        : byte to transmit, valid with o_tx_start
//   o_tx_start       : one-cycle transmit request
//   i_tx_done        : one-cycle byte-sent pulse from the transmitter
//   o_busy           : high whenever a dump is in progress
//   o_done           : one-cycle pulse after the final byte completes
//
// state       | meaning
// ST_IDLE     | waiting for i_start
// ST_HEADER   | pulse o_tx_start with the header byte (header build only)
// ST_HDR_WAIT | wait for the header byte to finish (header build only)
// ST_READ     | present idx on the bank read port
// ST_LATCH    | bank data valid; capture it into the serializer
// ST_SEND     | pulse o_tx_start with the current byte
// ST_WAIT_TX  | wait for i_tx_done, then pick next byte / register / finish
// ST_DONE     | pulse o_done
module register_dump_unit
  import dump_pkg::*;
#(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_addr_r,
  input  logic [NB_DATA-1:0] i_data_r,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGISTER - 1);

  dump_state_e       state_d, state_q;
  logic [NB_REG-1:0] idx_d, idx_q;

  logic               ser_clear;
  logic               ser_load;
  logic               ser_shift;
  logic [NB_BYTE-1:0] ser_byte;
  logic               ser_last;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (ser_clear),
    .i_load      (ser_load),
    .i_shift     (ser_shift),
    .i_word      (i_data_r),
    .o_byte      (ser_byte),
    .o_last_byte (ser_last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          idx_d = '0;
`ifdef DUMP_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_READ;
`endif
        end
      end
      ST_HEADER:   state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: if (i_tx_done) state_d = ST_READ;
      ST_READ:     state_d = ST_LATCH;
      ST_LATCH:    state_d = ST_SEND;
      ST_SEND:     state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (!ser_last) begin
            state_d = ST_SEND;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_clear  = (state_q == ST_IDLE) && i_start;
    ser_load   = (state_q == ST_LATCH);
    ser_shift  = (state_q == ST_WAIT_TX) && i_tx_done;
    o_addr_r   = idx_q;
    o_tx_start = (state_q == ST_SEND) || (state_q == ST_HEADER);
    o_tx_data  = (state_q == ST_HEADER) ? NB_BYTE'(DUMP_HEADER_BYTE) : ser_byte;
    o_busy     = (state_q != ST_IDLE);
    o_done     = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_register_dump_unit.sv
module tb_register_dump_unit;

  localparam int NB_REG     = 5;
  localparam int NB_DATA    = 32;
  localparam int N_REGISTER = 32;
  localparam int NB_BYTE    = 8;
  localparam int BPW        = NB_DATA / NB_BYTE;
`ifdef DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int MIN_DUMP_EDGES = 1 + N_REGISTER * (2 + BPW * 2) + 2 * HDR;

  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_start = 1'b0;
  logic [NB_REG-1:0]  o_addr_r;
  logic [NB_DATA-1:0] i_data_r;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done = 1'b0;
  logic               o_busy;
  logic               o_done;

  register_dump_unit #(
    .NB_REG     (NB_REG),
    .NB_DATA    (NB_DATA),
    .N_REGISTER (N_REGISTER),
    .NB_BYTE    (NB_BYTE)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_addr_r   (o_addr_r),
    .i_data_r   (i_data_r),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register bank with registered read port
  logic [NB_DATA-1:0] ref_regs [N_REGISTER];
  logic [NB_DATA-1:0] bank     [N_REGISTER];
  logic [NB_DATA-1:0] rd_q = '0;
  logic               load_bank = 1'b0;
  logic               we = 1'b0;
  logic [NB_REG-1:0]  wa = '0;
  logic [NB_DATA-1:0] wd = '0;

  always @(posedge clk) begin
    if (load_bank) begin
      for (int k = 0; k < N_REGISTER; k++) bank[k] <= ref_regs[k];
    end else if (we) begin
      bank[wa] <= wd;
    end
    rd_q <= bank[o_addr_r];
  end
  assign i_data_r = rd_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard state
  logic [NB_BYTE-1:0] exp_q[$];
  int exp_done    = 0;
  int start_cyc   = 0;
  bit chk_lat     = 1'b0;
  int bytes_seen  = 0;
  bit outstanding = 1'b0;

  // transmitter model
  int tx_lat      = 1;   // 0 selects a random latency per byte
  int tx_cnt      = 0;
  bit glitch_en   = 1'b0;
  bit glitch_hold = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_tx_done = 1'b0;
      if (glitch_hold) begin
        i_tx_done   = 1'b1;
        glitch_hold = 1'b0;
      end
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_tx_done = 1'b1;
          if (glitch_en) glitch_hold = 1'b1;
        end
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset) begin
        outstanding = 1'b0;
      end else begin
        if (i_tx_done && !o_tx_start) outstanding = 1'b0;
        if (o_tx_start) begin
          bytes_seen++;
          chk("tx_before_done", outstanding, 1'b0);
          chk("busy_during_tx", o_busy, 1'b1);
          if (exp_q.size() == 0) begin
            chk("unexpected_tx", 1'b1, 1'b0);
          end else begin
            chk("tx_byte", o_tx_data, exp_q.pop_front());
          end
          outstanding = 1'b1;
          tx_cnt = (tx_lat == 0) ? int'($urandom_range(1, 6)) : tx_lat;
        end
        if (o_done) begin
          chk("done_expected", (exp_done > 0), 1'b1);
          chk("bytes_left_at_done", exp_q.size(), 0);
          if (exp_done > 0) exp_done--;
          if (chk_lat) chk("dump_edges", cyc - start_cyc, MIN_DUMP_EDGES);
        end
      end
    end
  end

  task automatic preload(input bit rnd);
    for (int k = 0; k < N_REGISTER; k++)
      ref_regs[k] = rnd ? $urandom : (32'h11223300 + k);
    load_bank = 1'b1;
    @(posedge clk); #1;
    load_bank = 1'b0;
  endtask

  // called at posedge+#1
  task automatic issue_dump();
    if (HDR != 0) exp_q.push_back(8'hA5);
    for (int k = 0; k < N_REGISTER; k++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(NB_BYTE'((ref_regs[k] >> (NB_BYTE * b)) & 32'hFF));
    exp_done++;
    bytes_seen = 0;
    start_cyc  = cyc;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && exp_done == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dump_completed", ok, 1'b1);
    @(negedge clk);
    chk("busy_after_done", o_busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (bytes_seen >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_byte", ok, 1'b1);
    #1;
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tx_start", o_tx_start, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_addr", o_addr_r, '0);
    chk("rst_tx_data", o_tx_data, '0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // minimum-latency dump of the patterned bank
    preload(1'b0);
    tx_lat  = 1;
    chk_lat = 1'b1;
    issue_dump();
    drain(1000);
    chk_lat = 1'b0;

    // slow transmitter
    tx_lat = 10;
    issue_dump();
    drain(4000);

    // random contents, random transmitter latency
    preload(1'b1);
    tx_lat = 0;
    issue_dump();
    drain(4000);

    // second start at register 7 and done glitch during SEND
    tx_lat    = 1;
    glitch_en = 1'b1;
    issue_dump();
    wait_bytes(HDR + 7 * BPW + 1, 1000);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    drain(2000);
    glitch_en = 1'b0;

    // reset while byte 2 of register 5 is in flight
    preload(1'b1);
    issue_dump();
    wait_bytes(HDR + 5 * BPW + 3, 1000);
    i_reset = 1'b1;
    exp_q.delete();
    exp_done = 0;
    tx_cnt   = 0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 1'b0);
    chk("post_rst_tx_start", o_tx_start, 1'b0);
    chk("post_rst_done", o_done, 1'b0);
    chk("post_rst_addr", o_addr_r, '0);
    repeat (40) @(posedge clk);
    #1;
    issue_dump();
    drain(1000);

    // bank write during LATCH of register 3
    issue_dump();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_addr_r == NB_REG'(3)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_reg3", ok, 1'b1);
    @(posedge clk); #1;
    we = 1'b1;
    wa = NB_REG'(3);
    wd = 32'hDEADBEEF;
    ref_regs[3] = 32'hDEADBEEF;
    @(posedge clk); #1;
    we = 1'b0;
    drain(1000);
    issue_dump();
    drain(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
